// File: rtl/axis_output_depacketize_if.sv
// Bundles the AXIS input and the payload output stream of axis_output_depacketize.
// The slave modport is the depacketizer's view; the master modport is the driving side.
interface axis_output_depacketize_if #(
  parameter int unsigned TDATA_WIDTH   = 32,
  parameter int unsigned PAYLOAD_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = 16
);
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [TDATA_WIDTH-1:0]   s_axis_tdata;
  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                     s_axis_tlast;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAYLOAD_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]     out_cycle;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, out_ready,
    output s_axis_tready, out_valid, out_data, out_cycle
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, out_ready,
    input  s_axis_tready, out_valid, out_data, out_cycle
  );
endinterface

// File: rtl/axis_output_depacketize.sv
// Host-side receiver for the processor output stream: strips flagged payloads out of
// packetized AXIS words, tags them with their cycle index and queues them in a small FIFO.
module axis_output_depacketize #(
  parameter int unsigned TDATA_WIDTH   = 32,
  parameter int unsigned PAYLOAD_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_output_depacketize_if.slave      bus,
  output logic                          busy,
  output logic                          pkt_done,
  output logic [CNT_WIDTH-1:0]          pkt_cycles,
  output logic [CNT_WIDTH-1:0]          pkt_outputs,
  output logic [1:0]                    err,
  input  logic                          err_clear
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = AW + 1;
  localparam int unsigned PAD_W  = TDATA_WIDTH - 1 - PAYLOAD_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_busy;
  logic                     r_pkt_done;
  logic [CNT_WIDTH-1:0]     r_pkt_cycles;
  logic [CNT_WIDTH-1:0]     r_pkt_outputs;
  logic [1:0]               r_err;
  logic [CNT_WIDTH-1:0]     r_cyc_cnt;
  logic [CNT_WIDTH-1:0]     r_out_cnt;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PAYLOAD_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]     r_mem_cyc  [FIFO_DEPTH];

  logic                     w_full;
  logic                     w_empty;
  logic                     w_accept;
  logic                     w_flag;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_pkt_end;
  logic                     w_pad_nz;
  logic                     w_keep_bad;
  logic [1:0]               w_err_new;
  logic [PAYLOAD_WIDTH-1:0] w_payload;
  logic [CNT_WIDTH-1:0]     w_cyc_inc;
  logic [CNT_WIDTH-1:0]     w_out_inc;

  // Full when pointers differ only in the wrap bit.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign bus.s_axis_tready = !w_full && !rst;
  assign w_accept  = bus.s_axis_tvalid && bus.s_axis_tready;
  assign w_flag    = bus.s_axis_tdata[TDATA_WIDTH-1];
  assign w_payload = bus.s_axis_tdata[TDATA_WIDTH-2 -: PAYLOAD_WIDTH];
  assign w_push    = w_accept && w_flag;
  assign w_pop     = !w_empty && bus.out_ready;
  assign w_pkt_end = w_accept && bus.s_axis_tlast;

  generate
    if (PAD_W > 0) begin : g_pad
      assign w_pad_nz = |bus.s_axis_tdata[PAD_W-1:0];
    end else begin : g_no_pad
      assign w_pad_nz = 1'b0;
    end
  endgenerate

  assign w_keep_bad = (bus.s_axis_tkeep != '1);
  assign w_err_new  = {w_accept && w_flag && w_pad_nz, w_accept && w_keep_bad};

  // Saturating increments of the per-packet counters.
  assign w_cyc_inc = (&r_cyc_cnt) ? r_cyc_cnt : r_cyc_cnt + CNT_WIDTH'(1);
  assign w_out_inc = (&r_out_cnt) ? r_out_cnt : r_out_cnt + CNT_WIDTH'(1);

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = r_mem_data[r_rd_ptr[AW-1:0]];
  assign bus.out_cycle = r_mem_cyc[r_rd_ptr[AW-1:0]];

  assign busy        = r_busy;
  assign pkt_done    = r_pkt_done;
  assign pkt_cycles  = r_pkt_cycles;
  assign pkt_outputs = r_pkt_outputs;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = bus.s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= w_payload;
      r_mem_cyc[r_wr_ptr[AW-1:0]]  <= r_cyc_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_busy        <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_pkt_cycles  <= '0;
      r_pkt_outputs <= '0;
      r_err         <= '0;
      r_cyc_cnt     <= '0;
      r_out_cnt     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_busy     <= (w_state_nxt == ST_IN_PKT);
      r_pkt_done <= w_pkt_end;
      if (w_accept) begin
        if (bus.s_axis_tlast) begin
          r_pkt_cycles  <= w_cyc_inc;
          r_pkt_outputs <= w_flag ? w_out_inc : r_out_cnt;
          r_cyc_cnt     <= '0;
          r_out_cnt     <= '0;
        end else begin
          r_cyc_cnt <= w_cyc_inc;
          if (w_flag) begin
            r_out_cnt <= w_out_inc;
          end
        end
      end
      // A new error in the clearing cycle still lands.
      r_err <= (err_clear ? 2'b00 : r_err) | w_err_new;
    end
  end

endmodule

// File: tb/tb_axis_output_depacketize.sv
// Directed bench for axis_output_depacketize: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_axis_output_depacketize;

  localparam int unsigned TDW   = 32;
  localparam int unsigned PW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int          CMAX  = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic          pkt_done;
  logic [CW-1:0] pkt_cycles;
  logic [CW-1:0] pkt_outputs;
  logic [1:0]    err;
  logic          err_clear = 1'b0;

  always #5 clk = ~clk;

  axis_output_depacketize_if #(.TDATA_WIDTH(TDW), .PAYLOAD_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  axis_output_depacketize #(
    .TDATA_WIDTH(TDW), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .pkt_done(pkt_done),
    .pkt_cycles(pkt_cycles), .pkt_outputs(pkt_outputs), .err(err), .err_clear(err_clear)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit live  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Reference model: FIFO contents as a queue of {payload, cycle}, counters as integers.
  logic [PW+CW-1:0] m_q[$];
  int               m_cyc  = 0;
  int               m_outs = 0;
  int               m_pcyc = 0;
  int               m_pout = 0;
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  logic [1:0]       m_err  = 2'b00;

  always @(posedge clk) begin : model
    bit         pop;
    bit         acc;
    bit         flag;
    logic [1:0] ne;
    if (rst) begin
      m_q.delete();
      m_cyc = 0; m_outs = 0; m_pcyc = 0; m_pout = 0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 2'b00;
    end else begin
      pop    = (m_q.size() > 0) && bus.out_ready;
      acc    = bus.s_axis_tvalid && (m_q.size() < DEPTH);
      m_done = 1'b0;
      ne     = 2'b00;
      if (pop) m_q.delete(0);
      if (acc) begin
        flag = bus.s_axis_tdata[31];
        if (flag) m_q.push_back({bus.s_axis_tdata[30:23], 16'(m_cyc)});
        if (bus.s_axis_tkeep != 4'hF) ne[0] = 1'b1;
        if (flag && (bus.s_axis_tdata[22:0] != 23'd0)) ne[1] = 1'b1;
        if (bus.s_axis_tlast) begin
          m_pcyc = sat(m_cyc + 1);
          m_pout = sat(m_outs + int'(flag));
          m_cyc  = 0;
          m_outs = 0;
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_cyc  = sat(m_cyc + 1);
          m_outs = sat(m_outs + int'(flag));
          m_busy = 1'b1;
        end
      end
      m_err = (err_clear ? 2'b00 : m_err) | ne;
    end
  end

  always @(negedge clk) begin : compare
    if (live) begin
      chk("tready",      32'(bus.s_axis_tready), 32'(!rst && (m_q.size() < DEPTH)));
      chk("out_valid",   32'(bus.out_valid),     32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("out_data",  32'(bus.out_data),      32'(m_q[0][PW+CW-1:CW]));
        chk("out_cycle", 32'(bus.out_cycle),     32'(m_q[0][CW-1:0]));
      end
      chk("busy",        32'(busy),              32'(m_busy));
      chk("pkt_done",    32'(pkt_done),          32'(m_done));
      chk("pkt_cycles",  32'(pkt_cycles),        32'(m_pcyc));
      chk("pkt_outputs", 32'(pkt_outputs),       32'(m_pout));
      chk("err",         32'(err),               32'(m_err));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send(input logic [31:0] d, input logic last, input logic [3:0] keep);
    int guard;
    bit took;
    guard = 0;
    took  = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    bus.s_axis_tkeep  = keep;
    while (!took && guard < 200) begin
      took = bus.s_axis_tready;
      step();
      guard++;
    end
    bus.s_axis_tvalid = 1'b0;
    if (!took) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = 4'hF;
    bus.s_axis_tlast  = 1'b0;
    bus.out_ready     = 1'b1;
    rst               = 1'b1;
    repeat (3) step();
    chk("rst_tready",      32'(bus.s_axis_tready), 32'd0);
    chk("rst_out_valid",   32'(bus.out_valid),     32'd0);
    chk("rst_busy",        32'(busy),              32'd0);
    chk("rst_pkt_done",    32'(pkt_done),          32'd0);
    chk("rst_pkt_cycles",  32'(pkt_cycles),        32'd0);
    chk("rst_pkt_outputs", 32'(pkt_outputs),       32'd0);
    chk("rst_err",         32'(err),               32'd0);
    live = 1'b1;
    rst  = 1'b0;
    step();
    chk("post_rst_tready", 32'(bus.s_axis_tready), 32'd1);

    // Basic three-word packet with a trailing filler word.
    send(32'h8000_0000, 1'b0, 4'hF);
    chk("t1_busy1",  32'(busy),          32'd1);
    chk("t1_head0",  32'(bus.out_data),  32'h00);
    chk("t1_cyc0",   32'(bus.out_cycle), 32'd0);
    send(32'hAB00_0000, 1'b0, 4'hF);
    chk("t1_head1",  32'(bus.out_data),  32'h56);
    chk("t1_cyc1",   32'(bus.out_cycle), 32'd1);
    send(32'h0000_0000, 1'b1, 4'hF);
    chk("t1_done",   32'(pkt_done),      32'd1);
    chk("t1_cycles", 32'(pkt_cycles),    32'd3);
    chk("t1_outs",   32'(pkt_outputs),   32'd2);
    chk("t1_busy0",  32'(busy),          32'd0);
    step();
    chk("t1_done_pulse", 32'(pkt_done),  32'd0);

    // Single filler word packet from IDLE.
    send(32'h0000_0000, 1'b1, 4'hF);
    chk("t2_done",   32'(pkt_done),      32'd1);
    chk("t2_cycles", 32'(pkt_cycles),    32'd1);
    chk("t2_outs",   32'(pkt_outputs),   32'd0);
    chk("t2_busy",   32'(busy),          32'd0);
    chk("t2_valid",  32'(bus.out_valid), 32'd0);
    step();

    // Backpressure: fill the FIFO, then drain in order through a pointer wrap.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send({1'b1, 8'(8'h10 + i), 23'd0}, (i == 5), 4'hF);
        end
      end
      begin
        repeat (8) step();
        chk("t3_full_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("t3_head",        32'(bus.out_data),      32'h10);
        bus.out_ready = 1'b1;
      end
    join
    chk("t3_cycles", 32'(pkt_cycles),  32'd6);
    chk("t3_outs",   32'(pkt_outputs), 32'd6);
    repeat (6) step();
    chk("t3_drained", 32'(bus.out_valid), 32'd0);

    // Back-to-back two-word packets with no bubble.
    send(32'h8100_0000, 1'b0, 4'hF);
    send(32'h8200_0000, 1'b1, 4'hF);
    chk("t4_done_a", 32'(pkt_done),      32'd1);
    chk("t4_outs_a", 32'(pkt_outputs),   32'd2);
    send(32'h8300_0000, 1'b0, 4'hF);
    chk("t4_gap",    32'(pkt_done),      32'd0);
    chk("t4_head",   32'(bus.out_data),  32'h06);
    chk("t4_cyc",    32'(bus.out_cycle), 32'd0);
    send(32'h8400_0000, 1'b1, 4'hF);
    chk("t4_done_b", 32'(pkt_done),      32'd1);
    chk("t4_outs_b", 32'(pkt_outputs),   32'd2);
    step();

    // Sticky errors, clear, and set-over-clear.
    send(32'h8000_0001, 1'b1, 4'b0111);
    chk("t5_err",    32'(err),           32'd3);
    chk("t5_valid",  32'(bus.out_valid), 32'd1);
    chk("t5_data",   32'(bus.out_data),  32'h00);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t5_clear",  32'(err),           32'd0);
    err_clear = 1'b1;
    send(32'h8000_0001, 1'b1, 4'hF);
    err_clear = 1'b0;
    chk("t5_set_wins", 32'(err),         32'd2);
    step();

    // Reset in the middle of a packet.
    send(32'h8000_0000, 1'b0, 4'hF);
    send(32'h8100_0000, 1'b0, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid",  32'(bus.out_valid), 32'd0);
    chk("t6_busy",   32'(busy),          32'd0);
    chk("t6_done",   32'(pkt_done),      32'd0);
    chk("t6_err",    32'(err),           32'd0);
    step();
    chk("t6_done2",  32'(pkt_done),      32'd0);
    send(32'h8500_0000, 1'b0, 4'hF);
    chk("t6_head",   32'(bus.out_data),  32'h0A);
    chk("t6_cyc",    32'(bus.out_cycle), 32'd0);
    send(32'h0000_0000, 1'b0, 4'hF);
    send(32'h8600_0000, 1'b1, 4'hF);
    chk("t6_cycles", 32'(pkt_cycles),    32'd3);
    chk("t6_outs",   32'(pkt_outputs),   32'd2);

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
